ps2tx: RTL



---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_edge_sync.sv | 31 +++
 rtl/ps2tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, common command bytes
// and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5,
    ST_WAIT_IDLE = 3'd6,
    ST_DONE      = 3'd7
  } ps2tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] i_byte);
    return ~^i_byte;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchroniser for a raw PS/2 pin with a falling-edge strobe on the
// synchronised level. Shared with the keyboard receiver.
module ps2_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2tx.sv
// ps2tx: host-to-device PS/2 command transmitter driving open-collector pulls.
// Optional per-transfer watchdog is enabled by defining PS2TX_TIMEOUT_EN.
module ps2tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 48000000,
  parameter int INHIBIT_US = 110,
  parameter int TIMEOUT_MS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       dev_clk,
  input  logic       dev_dat,
  output logic       clk_pull,
  output logic       dat_pull,
  output logic       done,
  output logic       ack_ok,
  output logic       busy
);

  localparam int INHIBIT_CYC = CLK_HZ / 1000000 * INHIBIT_US;
`ifdef PS2TX_TIMEOUT_EN
  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int CNT_MAX     = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
`else
  localparam int CNT_MAX     = INHIBIT_CYC;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  logic         w_clk_s;
  logic         w_fall;
  logic         w_dat_s;
  logic         w_dat_fall;

  ps2tx_state_e r_state;
  logic [7:0]   r_data;
  logic [2:0]   r_bit;
  logic [CNT_W-1:0] r_cnt;

  ps2_edge_sync u_clk_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_pin  (dev_clk),
    .o_sync (w_clk_s),
    .o_fall (w_fall)
  );

  ps2_edge_sync u_dat_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_pin  (dev_dat),
    .o_sync (w_dat_s),
    .o_fall (w_dat_fall)
  );

  // Transfer sequencer; every output is registered and set on the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_data   <= 8'h00;
      r_bit    <= 3'd0;
      r_cnt    <= '0;
      tx_ready <= 1'b0;
      clk_pull <= 1'b0;
      dat_pull <= 1'b0;
      done     <= 1'b0;
      ack_ok   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            r_data   <= tx_data;
            r_cnt    <= '0;
            clk_pull <= 1'b1;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= ST_INHIBIT;
          end else begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          if (r_cnt == CNT_W'(INHIBIT_CYC - 1)) begin
            clk_pull <= 1'b0;
            dat_pull <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_START: begin
          if (w_fall) begin
            dat_pull <= ~r_data[0];
            r_bit    <= 3'd0;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_fall) begin
            if (r_bit == 3'd7) begin
              dat_pull <= ~ps2_odd_parity(r_data);
              r_state  <= ST_PARITY;
            end else begin
              dat_pull <= ~r_data[r_bit + 3'd1];
              r_bit    <= r_bit + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_fall) begin
            dat_pull <= 1'b0;
            r_state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          // The device answers by holding data low across the final clock.
          if (w_fall) begin
            ack_ok  <= ~w_dat_s;
            r_state <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (w_clk_s && w_dat_s) begin
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          clk_pull <= 1'b0;
          dat_pull <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
`ifdef PS2TX_TIMEOUT_EN
      // Watchdog restarts on each device clock; a silent device aborts the transfer.
      if ((r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_PARITY) ||
          (r_state == ST_STOP) || (r_state == ST_WAIT_IDLE)) begin
        if (w_fall) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          clk_pull <= 1'b0;
          dat_pull <= 1'b0;
          ack_ok   <= 1'b0;
          done     <= 1'b1;
          r_state  <= ST_DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
